mc_processor_p: RTL and testbench

//  Parametrised multicycle processor core: fetch/decode/execute FSM, register file (PC = top register),
//  ALU and memory port with MemReady handshake, so slow memories can stall the core.

---
 rtl/mc_processor_p.sv | 183 ++++++++++++++++++
 tb/tb_mc_processor_p.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mc_processor_p.sv
// Multicycle processor core: FETCH/FWAIT/EXEC/MWAIT/HALT sequencer, register file
// with the PC in the top register, and a single memory port stalled by MemReady.
module mc_processor_p #(
  parameter int             DW       = 16,
  parameter int             NREG     = 8,
  parameter logic [DW-1:0]  RESET_PC = '0
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [DW-1:0] DataIn,
  input  logic          MemReady,
  output logic [DW-1:0] Daddress,
  output logic [DW-1:0] Dout,
  output logic          R,
  output logic          W,
  output logic          Halted
);

  localparam int RW  = $clog2(NREG);
  localparam int PCI = NREG - 1;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_FWAIT = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MWAIT = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1000;
  localparam logic [3:0] OP_CMOV = 4'b1011;
  localparam logic [3:0] OP_ST   = 4'b1100;
  localparam logic [3:0] OP_LD   = 4'b1101;
  localparam logic [3:0] OP_MOV  = 4'b1110;
  localparam logic [3:0] OP_LDI  = 4'b1111;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] daddr_q, daddr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          r_q, r_d;
  logic          w_q, w_d;

  logic [3:0]    op;
  logic [RW-1:0] rdIdx, raIdx, rbIdx;
  logic [DW-1:0] rdVal, raVal, rbVal, pcVal;
  logic [DW-1:0] aluRes;
  logic          aluWe;

  assign op    = ir_q[DW-1 -: 4];
  assign rdIdx = ir_q[DW-5 -: RW];
  assign raIdx = ir_q[DW-5-RW -: RW];
  assign rbIdx = ir_q[DW-5-2*RW -: RW];
  assign rdVal = regs_q[rdIdx];
  assign raVal = regs_q[raIdx];
  assign rbVal = regs_q[rbIdx];
  assign pcVal = regs_q[PCI];

  generate
    if (DW > 4 + 3*RW) begin : gUnusedIr
      logic unusedIrBits;
      assign unusedIrBits = ^ir_q[DW-5-3*RW:0];
    end
  endgenerate

  // Register-writing ALU results; CMOV only writes when rb is non-zero.
  always_comb begin
    aluRes = '0;
    aluWe  = 1'b0;
    case (op)
      OP_ADD:  begin aluRes = raVal + rbVal;    aluWe = 1'b1; end
      OP_OR:   begin aluRes = raVal | rbVal;    aluWe = 1'b1; end
      OP_AND:  begin aluRes = raVal & rbVal;    aluWe = 1'b1; end
      OP_NOT:  begin aluRes = ~raVal;           aluWe = 1'b1; end
      OP_SUB:  begin aluRes = raVal - rbVal;    aluWe = 1'b1; end
      OP_XOR:  begin aluRes = raVal ^ rbVal;    aluWe = 1'b1; end
      OP_SHL:  begin aluRes = raVal << 1;       aluWe = 1'b1; end
      OP_CMOV: begin aluRes = raVal;            aluWe = (rbVal != '0); end
      OP_MOV:  begin aluRes = raVal;            aluWe = 1'b1; end
      default: begin aluRes = '0;               aluWe = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    daddr_d = daddr_q;
    dout_d  = dout_q;
    r_d     = r_q;
    w_d     = w_q;
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];

    case (state_q)
      S_FETCH: begin
        daddr_d = pcVal;
        r_d     = 1'b1;
        state_d = S_FWAIT;
      end
      S_FWAIT: begin
        if (MemReady) begin
          ir_d        = DataIn;
          regs_d[PCI] = pcVal + DW'(1);
          r_d         = 1'b0;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_LD: begin
            daddr_d = raVal;
            r_d     = 1'b1;
            state_d = S_MWAIT;
          end
          OP_LDI: begin
            daddr_d = pcVal;
            r_d     = 1'b1;
            state_d = S_MWAIT;
          end
          OP_ST: begin
            daddr_d = raVal;
            dout_d  = rdVal;
            w_d     = 1'b1;
            state_d = S_MWAIT;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            if (aluWe) regs_d[rdIdx] = aluRes;
            state_d = S_FETCH;
          end
        endcase
      end
      // The rd write comes after the PC increment so a load into the PC wins.
      S_MWAIT: begin
        if (MemReady) begin
          r_d = 1'b0;
          w_d = 1'b0;
          if (op == OP_LDI) regs_d[PCI] = pcVal + DW'(1);
          if (op == OP_LD || op == OP_LDI) regs_d[rdIdx] = DataIn;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        r_d = 1'b0;
        w_d = 1'b0;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      daddr_q <= '0;
      dout_q  <= '0;
      r_q     <= 1'b0;
      w_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= (i == PCI) ? RESET_PC : '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      daddr_q <= daddr_d;
      dout_q  <= dout_d;
      r_q     <= r_d;
      w_q     <= w_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign Daddress = daddr_q;
  assign Dout     = dout_q;
  assign R        = r_q;
  assign W        = w_q;
  assign Halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_mc_processor_p.sv
// Directed-program bench for mc_processor_p: a small word memory model drives DataIn,
// and each step checks outputs and register contents against hand-computed values.
module tb_mc_processor_p;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        MemReady = 1'b1;
  logic [15:0] DataIn;
  logic [15:0] Daddress;
  logic [15:0] Dout;
  logic        R, W, Halted;

  logic [15:0] mem [64];
  int          vectors = 0;
  int          miscompares = 0;
  int          wCount = 0;
  int          rwCount = 0;
  logic [15:0] lastWAddr = '0;
  logic [15:0] lastWData = '0;
  int          wBase, rwBase;

  mc_processor_p #(.DW(16), .NREG(8), .RESET_PC(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .MemReady(MemReady),
    .Daddress(Daddress), .Dout(Dout), .R(R), .W(W), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  assign DataIn = mem[Daddress[5:0]];

  // Records completed write handshakes and any bus activity for later checks.
  always @(posedge Clock) begin
    if (!Reset && W && MemReady) begin
      wCount    <= wCount + 1;
      lastWAddr <= Daddress;
      lastWData <= Dout;
    end
    if (R || W) rwCount <= rwCount + 1;
  end

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    Reset    = 1'b1;
    MemReady = 1'b1;
    applyStimulus(2);
    Reset = 1'b0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    // Program 1: LDI r1,5; LDI r2,7; ADD r3=r1+r2; ST mem[r1]=r3
    clearMem();
    mem[0] = 16'hF200; mem[1] = 16'h0005; mem[2] = 16'hF400;
    mem[3] = 16'h0007; mem[4] = 16'h0650; mem[5] = 16'hC640;
    resetDut();
    checkOutput("rst_R", {15'd0, R}, 16'h0000);
    checkOutput("rst_W", {15'd0, W}, 16'h0000);
    checkOutput("rst_Halted", {15'd0, Halted}, 16'h0000);
    checkOutput("rst_Daddress", Daddress, 16'h0000);
    checkOutput("rst_Dout", Dout, 16'h0000);
    checkOutput("rst_PC", dut.regs_q[7], 16'h0000);
    wBase = wCount;
    applyStimulus(15);
    checkOutput("p1_r1", dut.regs_q[1], 16'h0005);
    checkOutput("p1_r2", dut.regs_q[2], 16'h0007);
    checkOutput("p1_r3", dut.regs_q[3], 16'h000C);
    checkOutput("p1_PC", dut.regs_q[7], 16'h0006);
    checkOutput("p1_wpulses", 16'(wCount - wBase), 16'h0001);
    checkOutput("p1_waddr", lastWAddr, 16'h0005);
    checkOutput("p1_wdata", lastWData, 16'h000C);

    // Program 2: fetch stalled three cycles by MemReady=0
    clearMem();
    mem[0] = 16'hF200; mem[1] = 16'h0005;
    resetDut();
    MemReady = 1'b0;
    applyStimulus(1);
    checkOutput("stall_R_t1", {15'd0, R}, 16'h0001);
    applyStimulus(3);
    checkOutput("stall_R_t4", {15'd0, R}, 16'h0001);
    checkOutput("stall_Daddress", Daddress, 16'h0000);
    checkOutput("stall_PC", dut.regs_q[7], 16'h0000);
    checkOutput("stall_r1", dut.regs_q[1], 16'h0000);
    MemReady = 1'b1;
    applyStimulus(2);
    checkOutput("stall_mwait_R", {15'd0, R}, 16'h0001);
    checkOutput("stall_mwait_Daddress", Daddress, 16'h0001);
    checkOutput("stall_mwait_PC", dut.regs_q[7], 16'h0001);
    checkOutput("stall_mwait_r1", dut.regs_q[1], 16'h0000);
    applyStimulus(1);
    checkOutput("stall_done_r1", dut.regs_q[1], 16'h0005);
    checkOutput("stall_done_PC", dut.regs_q[7], 16'h0002);

    // Program 3: CMOV r3=r1 if r0 (no write), then if r5=1 (write)
    clearMem();
    mem[0] = 16'hF200; mem[1] = 16'h1234; mem[2] = 16'hB640;
    mem[3] = 16'hFA00; mem[4] = 16'h0001; mem[5] = 16'hB668;
    resetDut();
    applyStimulus(7);
    checkOutput("cmov_rb0_r3", dut.regs_q[3], 16'h0000);
    applyStimulus(7);
    checkOutput("cmov_rb1_r5", dut.regs_q[5], 16'h0001);
    checkOutput("cmov_rb1_r3", dut.regs_q[3], 16'h1234);

    // Program 4: ALU wraparound and logic ops
    clearMem();
    mem[0]  = 16'hF200; mem[1]  = 16'hFFFF; mem[2]  = 16'hF400; mem[3]  = 16'h0001;
    mem[4]  = 16'hE640; mem[5]  = 16'h0650; mem[6]  = 16'h4810; mem[7]  = 16'hFA00;
    mem[8]  = 16'h8001; mem[9]  = 16'h6D40; mem[10] = 16'h3680; mem[11] = 16'h5948;
    mem[12] = 16'h2750; mem[13] = 16'h18B0;
    resetDut();
    applyStimulus(11);
    checkOutput("alu_mov_r3", dut.regs_q[3], 16'hFFFF);
    applyStimulus(3);
    checkOutput("alu_add_wrap", dut.regs_q[3], 16'h0000);
    applyStimulus(3);
    checkOutput("alu_sub_wrap", dut.regs_q[4], 16'hFFFF);
    applyStimulus(7);
    checkOutput("alu_shl", dut.regs_q[6], 16'h0002);
    applyStimulus(3);
    checkOutput("alu_not", dut.regs_q[3], 16'hFFFE);
    applyStimulus(3);
    checkOutput("alu_xor", dut.regs_q[4], 16'h7FFE);
    applyStimulus(3);
    checkOutput("alu_and", dut.regs_q[3], 16'h0001);
    applyStimulus(3);
    checkOutput("alu_or", dut.regs_q[4], 16'h0003);

    // Program 5: MOV into PC redirects the fetch, which lands on HALT
    clearMem();
    mem[0] = 16'hF200; mem[1] = 16'h0020; mem[2] = 16'hEE40; mem[32] = 16'h8000;
    resetDut();
    applyStimulus(8);
    checkOutput("jump_R", {15'd0, R}, 16'h0001);
    checkOutput("jump_Daddress", Daddress, 16'h0020);
    applyStimulus(1);
    checkOutput("pre_halt_Halted", {15'd0, Halted}, 16'h0000);
    applyStimulus(1);
    checkOutput("halt_Halted", {15'd0, Halted}, 16'h0001);
    rwBase = rwCount;
    applyStimulus(20);
    checkOutput("halt_no_rw", 16'(rwCount - rwBase), 16'h0000);
    checkOutput("halt_still", {15'd0, Halted}, 16'h0001);
    checkOutput("halt_PC", dut.regs_q[7], 16'h0021);

    // Program 6: Reset while ST waits in MWAIT with W high
    clearMem();
    mem[0] = 16'hF200; mem[1] = 16'h0005; mem[2] = 16'hC240;
    resetDut();
    applyStimulus(6);
    MemReady = 1'b0;
    applyStimulus(1);
    checkOutput("st_W", {15'd0, W}, 16'h0001);
    checkOutput("st_R", {15'd0, R}, 16'h0000);
    checkOutput("st_Daddress", Daddress, 16'h0005);
    checkOutput("st_Dout", Dout, 16'h0005);
    applyStimulus(1);
    checkOutput("st_W_held", {15'd0, W}, 16'h0001);
    wBase = wCount;
    Reset = 1'b1;
    applyStimulus(1);
    checkOutput("abort_W", {15'd0, W}, 16'h0000);
    checkOutput("abort_R", {15'd0, R}, 16'h0000);
    checkOutput("abort_PC", dut.regs_q[7], 16'h0000);
    checkOutput("abort_r1", dut.regs_q[1], 16'h0000);
    checkOutput("abort_Daddress", Daddress, 16'h0000);
    checkOutput("abort_Dout", Dout, 16'h0000);
    Reset    = 1'b0;
    MemReady = 1'b1;
    applyStimulus(1);
    checkOutput("restart_R", {15'd0, R}, 16'h0001);
    checkOutput("restart_Daddress", Daddress, 16'h0000);
    checkOutput("abort_no_write", 16'(wCount - wBase), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
